wave_capture: RTL



---
 rtl/wave_pkg.sv | 21 ++
 rtl/wave_trigger_detect.sv | 49 ++++
 rtl/wave_capture.sv | 115 +++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wave_pkg
// Brief   : Shared widths and capture-state encoding for the waveform path.
// Revision: 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int DISP_W      = 8;
    localparam int WAVE_ADDR_W = 9;
    localparam int NUM_POINTS  = 256;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_e;

endpackage
`default_nettype wire

// File: rtl/wave_trigger_detect.sv
`default_nettype none
// ============================================================================
// Module  : wave_trigger_detect
// Brief   : Sample accept gating and rising zero-crossing detection.
//           WAVE_CAPTURE_DECIMATE_EN: accept only every second strobe.
// Revision: 1.0 - initial release
// ============================================================================
module wave_trigger_detect
    import wave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready_i,
    input  logic sample_sign_i,
    output logic accept_o,
    output logic trigger_o
);

    // Only the sign of the previous sample ever feeds the crossing test.
    logic prev_sign_q;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else if (new_sample_ready_i) begin
            phase_q <= ~phase_q;
        end
    end

    assign accept_o = new_sample_ready_i & ~phase_q;
`else
    assign accept_o = new_sample_ready_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sign_q <= 1'b0;
        end else if (accept_o) begin
            prev_sign_q <= sample_sign_i;
        end
    end

    assign trigger_o = accept_o & prev_sign_q & ~sample_sign_i;

endmodule
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module  : wave_capture
// Brief   : Triggered 256-sample capture into the hidden half of a
//           double-buffered waveform RAM. Option: WAVE_CAPTURE_DECIMATE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module wave_capture #(
    parameter int NUM_POINTS = wave_pkg::NUM_POINTS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            new_sample_ready,
    input  logic [wave_pkg::SAMPLE_W-1:0]   new_sample_in,
    input  logic                            wave_display_idle,
    output logic [wave_pkg::WAVE_ADDR_W-1:0] write_address,
    output logic                            write_enable,
    output logic [wave_pkg::DISP_W-1:0]     write_sample,
    output logic                            read_index
);
    import wave_pkg::*;

    localparam logic [7:0] LAST_INDEX = 8'(NUM_POINTS - 1);

    wave_state_e              state_q, state_d;
    logic [7:0]               index_q, index_d;
    logic                     read_index_q, read_index_d;
    logic                     write_enable_q, write_enable_d;
    logic [WAVE_ADDR_W-1:0]   write_address_q, write_address_d;
    logic [DISP_W-1:0]        write_sample_q, write_sample_d;

    logic                     w_accept;
    logic                     w_trigger;
    logic [DISP_W-1:0]        w_disp;
    logic                     unused_low_bits;

    wave_trigger_detect u_trigger (
        .clk                (clk),
        .reset              (reset),
        .new_sample_ready_i (new_sample_ready),
        .sample_sign_i      (new_sample_in[SAMPLE_W-1]),
        .accept_o           (w_accept),
        .trigger_o          (w_trigger)
    );

    // Offset binary: signed upper byte with its sign bit flipped.
    assign w_disp          = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-DISP_W]};
    assign unused_low_bits = ^new_sample_in[SAMPLE_W-DISP_W-1:0];

    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        case (state_q)
            ARMED: begin
                if (w_trigger) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, 8'd0};
                    write_sample_d  = w_disp;
                    index_d         = 8'd1;
                    state_d         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_accept) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, index_q};
                    write_sample_d  = w_disp;
                    index_d         = index_q + 8'd1;
                    if (index_q == LAST_INDEX) begin
                        index_d = 8'd0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ARMED;
            index_q         <= 8'd0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule
`default_nettype wire
